// File: rtl/ram_sdp_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_sdp_param_if                                                   |
// | Write/read bus of the simple-dual-port RAM.                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface ram_sdp_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we_in;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  re_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  busy_out;

    modport master (
        output data_in, write_addr, we_in, read_addr, re_in,
        input  data_out, valid_out, busy_out
    );

    modport slave (
        input  data_in, write_addr, we_in, read_addr, re_in,
        output data_out, valid_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/ram_sdp_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_sdp_param                                                      |
// | Parametrised simple-dual-port RAM, 1/2-cycle read latency, RDW     |
// | policy select; clear-on-reset engine built when RAM_CLEAR_EN set.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ram_sdp_param #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    READ_LATENCY = 1,
    parameter int                    RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic          clk,
    input  logic          rst,
    ram_sdp_param_if.slave ram_io
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

`ifdef RAM_CLEAR_EN
    localparam state_e RESET_STATE = CLEAR;
`else
    localparam state_e RESET_STATE = READY;
`endif

    state_e                  state_q;
    state_e                  state_d;
    logic                    busy;
    logic [ADDR_WIDTH-1:0]   clr_addr;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    res_valid;
    logic [DATA_WIDTH-1:0]   res_data;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    valid_q;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_sdp_param: READ_LATENCY must be 1 or 2");
    end

    // ---------------- control FSM ----------------
`ifdef RAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clr_addr = clr_cnt_q;
    assign busy     = (state_q == CLEAR);
`else
    always_comb begin
        state_d = state_q;
        state_d = READY;
    end

    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- storage access ----------------
    // The clear engine owns the write port while busy; user traffic is dropped.
    always_comb begin
        wr_en   = !rst && (busy || ram_io.we_in);
        wr_addr = busy ? clr_addr : ram_io.write_addr;
        wr_data = busy ? CLEAR_VALUE : ram_io.data_in;
        rd_en   = !rst && !busy && ram_io.re_in;
        rd_word = mem_q[ram_io.read_addr];
        if (RDW_MODE != 0 && !busy && wr_en && (ram_io.write_addr == ram_io.read_addr)) begin
            rd_word = ram_io.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // ---------------- read pipeline ----------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_valid_q;
        logic [DATA_WIDTH-1:0] s1_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_en;
                if (rd_en) begin
                    s1_data_q <= rd_word;
                end
            end
        end

        assign res_valid = s1_valid_q;
        assign res_data  = s1_data_q;
    end else begin : g_lat1
        assign res_valid = rd_en;
        assign res_data  = rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= res_valid;
            if (res_valid) begin
                data_out_q <= res_data;
            end
        end
    end

    assign ram_io.data_out  = data_out_q;
    assign ram_io.valid_out = valid_q;
    assign ram_io.busy_out  = busy;

endmodule
`default_nettype wire

// File: doc/ram_sdp_param.md
# ram_sdp_param

Parametrised simple-dual-port synchronous RAM with one write port and one read port on a single clock, the next generation of the team's fixed 64x8 RAM blocks. Adds configurable width/depth, a read-enable with a matching valid strobe, a selectable read latency, a defined read-during-write policy and an optional clear-on-reset engine that initialises every word after reset. Intended as the standard on-chip storage primitive for buffers and lookup tables across the design.

## Interface
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH words
- READ_LATENCY, 1, 1 or 2 clock edges from read request to data; other values are illegal
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data
- CLEAR_VALUE, 0, word written to every location by the clear engine

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH  write data
- write_addr  in  ADDR_WIDTH  write address
- we_in  in  1  write enable
- read_addr  in  ADDR_WIDTH  read address
- re_in  in  1  read enable
- data_out  out  DATA_WIDTH  read data, registered
- valid_out  out  1  one-cycle strobe, data_out holds a fresh read result
- busy_out  out  1  clear engine active; writes and reads are ignored

## Operation
- FSM states: CLEAR (engine writing), READY (normal access).
- rst high at an edge: state <- CLEAR, clear counter <- 0, read pipeline flushed.
- CLEAR: each edge writes CLEAR_VALUE to address counter, counter +1; edge that writes depth-1 moves to READY. we_in and re_in ignored, no valid_out.
- READY: we_in=1 writes data_in to write_addr; re_in=1 reads read_addr.
- Read-during-write to same address on same edge: RDW_MODE=0 returns stored (old) word; RDW_MODE=1 returns data_in. Different addresses: no interaction.
- data_out holds its last value when no read completes; changes only together with valid_out=1.
- Back-to-back reads every cycle supported; one result per cycle, in order.
- Addresses wrap naturally at ADDR_WIDTH bits; no out-of-range case exists.
- Reset mid-clear or mid-read: clear restarts at address 0; in-flight reads dropped, valid_out never asserts for them.

## Timing
- During and after rst: data_out = 0, valid_out = 0, busy_out = 1 (clear compiled in) or 0 (compiled out).
- busy_out stays high for exactly 2**ADDR_WIDTH edges after first edge with rst=0; deasserts on the edge writing the last word. First accepted access: next edge.
- READ_LATENCY=1: re_in sampled at edge N -> data_out/valid_out updated at edge N.
- READ_LATENCY=2: re_in sampled at edge N -> data_out/valid_out updated at edge N+1.
- Write visible to a read sampled on a later edge; same-edge case governed by RDW_MODE.

## Configuration
- RAM_CLEAR_EN defined: CLEAR state and counter built in; behaviour as above.
- RAM_CLEAR_EN undefined: no clear engine; FSM held in READY, busy_out tied 0; memory contents after reset are undefined (X in simulation) until written; CLEAR_VALUE unused. Reset still clears data_out, valid_out and the read pipeline.

## Test plan
- Clear: RAM_CLEAR_EN, CLEAR_VALUE=8'hA5, rst for 2 cycles -> busy_out high exactly 64 cycles; reads of addresses 0, 31, 63 return 8'hA5 with valid_out.
- Fill/readback: write data=addr to all 64 addresses, then read 0..63 back-to-back -> data_out=0..63 in order, valid_out high 64 consecutive cycles, latency 1 and 2 each checked.
- Collision: addr 5 holds 8'h11, same edge we_in=1 data_in=8'h22 and re_in=1 at addr 5 -> RDW_MODE=0 gives 8'h11, RDW_MODE=1 gives 8'h22; next read gives 8'h22.
- Busy lockout: we_in=1 to addr 3 with 8'hFF and re_in=1 during CLEAR -> no valid_out; after clear, addr 3 reads CLEAR_VALUE.
- Reset mid-operation: rst asserted at clear counter 20, and again with a read in flight at latency 2 -> clear restarts (busy_out high 64 cycles after release), no stray valid_out, data_out = 0.
- Width/depth: DATA_WIDTH=16, ADDR_WIDTH=4 -> write 16'hBEEF to addr 15, read back 16'hBEEF; write to addr 0 does not disturb addr 15.
